edit_sequencer: RTL and testbench
=================================

Name: edit_sequencer

Overview:
- Sequences the 32-bit output-buffer datapath: on each interception event, first loads the intercepted word, then applies a programmed list of single-bit edits, one edit per cycle.
- Each edit is an (address, value, condition) entry; the condition is evaluated against live condition flags.
- Sits between the config/host interface and the output buffer. Drives that buffer's addr, do_write, val, en_edit, en_load_input and mux_data.

Parameters:
- N_EDITS, 8, depth of the edit table (legal range 1..32).
- IDXW, $clog2(N_EDITS), width of the table index.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- cfg_we, input, 1, write one edit-table entry at cfg_idx.
- cfg_idx, input, IDXW, table entry index.
- cfg_addr, input, 5, bit position this entry edits.
- cfg_val, input, 1, value written by this entry.
- cfg_mode, input, 2, condition mode: 00 NEVER, 01 ALWAYS, 10 IF_SET, 11 IF_CLR.
- cfg_flag, input, 2, index into cond_flags used by IF_SET and IF_CLR.
- cfg_len_we, input, 1, write the active edit count.
- cfg_len, input, IDXW+1, number of entries to apply, starting from index 0.
- cond_flags, input, 4, live condition flags.
- start, input, 1, interception event: begin a sequence.
- abort, input, 1, cancel the sequence in progress.
- busy, output, 1, high while in LOAD or EDIT.
- done, output, 1, one-cycle pulse; out_buf holds the final result in this cycle.
- addr, output, 5, edit address to the datapath.
- do_write, output, 1, evaluated condition for the current edit.
- val, output, 1, edit value.
- en_edit, output, 1, edit enable.
- en_load_input, output, 1, load enable for the intercepted word.
- mux_data, output, 1, data-source select: 0 = intercepted input, 1 = val.

Behaviour:
- Reset (reset_n low, asynchronous):
  - State is IDLE.
  - All outputs are 0.
  - Every table entry is mode NEVER, addr 0, val 0, flag 0.
  - Active length is 0.
  - Reset in the middle of a sequence abandons it immediately; no done pulse is produced.
- FSM states: IDLE, LOAD, EDIT, DONE. State, idx, addr, val, en_edit, en_load_input, mux_data and busy are registered.
- IDLE:
  - Configuration writes are accepted only in IDLE. cfg_we and cfg_len_we outside IDLE are ignored.
  - A cfg_len write greater than N_EDITS stores N_EDITS.
  - start high -> go to LOAD.
- LOAD (exactly 1 cycle):
  - en_load_input=1, mux_data=0, en_edit=0.
  - If length is 0 -> go to DONE; otherwise idx=0 and go to EDIT.
- EDIT (one cycle per entry):
  - en_edit=1, mux_data=1, en_load_input=0.
  - addr and val come from entry idx.
  - do_write is combinational from entry idx and the current cond_flags:
    - NEVER -> 0
    - ALWAYS -> 1
    - IF_SET -> cond_flags[flag]
    - IF_CLR -> ~cond_flags[flag]
  - idx == length-1 -> go to DONE; otherwise idx increments by 1.
- DONE (1 cycle): done=1, all enables 0, then go to IDLE.
- Timing: with start sampled at edge T:
  - en_load_input is high in cycle T+1.
  - Edits occupy cycles T+2 .. T+1+len.
  - done is high in cycle T+2+len (T+2 when len is 0).
- start while not in IDLE is ignored; there is no queueing.
- abort (any state except IDLE): the next state is IDLE, all enables drop at that edge, and no done pulse is produced.
- abort takes priority over start and over normal transitions.
- When the sequence is not in EDIT, do_write is 0.
- Duplicate addresses in the table are allowed; the later entry wins.

Decomposition:
- Package edit_seq_pkg:
  - FSM state enum.
  - Condition-mode constants (MODE_NEVER, MODE_ALWAYS, MODE_IF_SET, MODE_IF_CLR).
  - Entry struct {addr[4:0], val, mode[1:0], flag[1:0]}.
- One sub-module, edit_table:
  - N_EDITS x 10-bit register file.
  - One synchronous write port and one combinational read port.
  - Asynchronous active-low clear.
- The FSM, length register and condition evaluation stay in edit_sequencer.

Test Plan:
- Reset then start with no configuration -> en_load_input high for 1 cycle; en_edit never asserted; done at T+2; busy high only in cycle T+1.
- Program len=3, entries {5,1,ALWAYS}, {0,0,ALWAYS}, {31,1,NEVER}; start -> addr sequence 5, 0, 31 in cycles T+2..T+4 with do_write 1, 1, 0 and mux_data=1; done at T+5. With a buffer model loaded with 0x0000_0001, the final result is 0x0000_0020.
- Entry {7,1,IF_SET,flag=2}; toggle cond_flags[2] 0->1 in the edit cycle -> do_write follows the flag combinationally in that same cycle. With IF_CLR the value is inverted.
- Apply abort during the 2nd of 4 edits -> next cycle is IDLE with all enables 0; done never pulses; a new start is accepted one cycle later.
- cfg_len=15 with N_EDITS=8 -> stored as 8; exactly 8 edit cycles. A cfg_we issued while busy leaves the table unchanged (verified by a following run).
- Drive reset_n low asynchronously mid-EDIT -> outputs clear without waiting for a clock edge; after release the table is cleared, so a start performs only the load.

Source files
------------

// File: rtl/edit_seq_pkg.sv
// rtl/edit_seq_pkg.sv - shared types and helpers for the edit sequencer
//
// Purpose: FSM state encoding, condition-mode constants, the packed edit-table
//          entry and the condition evaluation used while editing.
// Ports:   none (package).
package edit_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EDIT,
    ST_DONE
  } state_t;

  localparam logic [1:0] MODE_NEVER  = 2'b00;
  localparam logic [1:0] MODE_ALWAYS = 2'b01;
  localparam logic [1:0] MODE_IF_SET = 2'b10;
  localparam logic [1:0] MODE_IF_CLR = 2'b11;

  // 10-bit table entry; an all-zero entry is "NEVER, addr 0, val 0, flag 0".
  typedef struct packed {
    logic [4:0] addr;
    logic       val;
    logic [1:0] mode;
    logic [1:0] flag;
  } entry_t;

  function automatic logic eval_cond(input entry_t e, input logic [3:0] flags);
    logic r;
    case (e.mode)
      MODE_NEVER:  r = 1'b0;
      MODE_ALWAYS: r = 1'b1;
      MODE_IF_SET: r = flags[e.flag];
      default:     r = ~flags[e.flag];
    endcase
    return r;
  endfunction

endpackage

// File: rtl/edit_table.sv
// rtl/edit_table.sv - edit-table register file
//
// Purpose: N_EDITS x 10-bit entry storage, one synchronous write port and one
//          combinational read port, asynchronously cleared to all-NEVER.
// Ports:   clk, reset_n       - clock, async active-low clear
//          we, widx, wdata    - write strobe, entry index, entry contents
//          ridx, rdata        - read index, entry contents (combinational)
module edit_table
  import edit_seq_pkg::*;
#(
  parameter int N_EDITS = 8,
  parameter int IDXW    = 3
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            we,
  input  logic [IDXW-1:0] widx,
  input  entry_t          wdata,
  input  logic [IDXW-1:0] ridx,
  output entry_t          rdata
);

  entry_t mem [N_EDITS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_EDITS; i++) mem[i] <= '0;
    end else if (we && (int'(widx) < N_EDITS)) begin
      mem[widx] <= wdata;
    end
  end

  // Indices past the table depth (non-power-of-two depths) read as NEVER.
  assign rdata = (int'(ridx) < N_EDITS) ? mem[ridx] : '0;

endmodule

// File: rtl/edit_sequencer.sv
// rtl/edit_sequencer.sv - output-buffer load/edit sequencer
//
// Purpose: on start, loads the intercepted word (one cycle) then walks the
//          programmed edit list one entry per cycle, then pulses done.
// Ports:   clk, reset_n                       - clock, async active-low reset
//          cfg_we/idx/addr/val/mode/flag      - edit-table write (IDLE only)
//          cfg_len_we, cfg_len                - active edit count (clamped)
//          cond_flags                         - live condition flags
//          start, abort                       - begin / cancel a sequence
//          busy, done                         - status
//          addr, do_write, val, en_edit,
//          en_load_input, mux_data            - output-buffer datapath controls
module edit_sequencer
  import edit_seq_pkg::*;
#(
  parameter int N_EDITS = 8,
  parameter int IDXW    = (N_EDITS > 1) ? $clog2(N_EDITS) : 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            cfg_we,
  input  logic [IDXW-1:0] cfg_idx,
  input  logic [4:0]      cfg_addr,
  input  logic            cfg_val,
  input  logic [1:0]      cfg_mode,
  input  logic [1:0]      cfg_flag,
  input  logic            cfg_len_we,
  input  logic [IDXW:0]   cfg_len,
  input  logic [3:0]      cond_flags,
  input  logic            start,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic [4:0]      addr,
  output logic            do_write,
  output logic            val,
  output logic            en_edit,
  output logic            en_load_input,
  output logic            mux_data
);

  localparam int            LEN_W   = IDXW + 1;
  localparam logic [IDXW:0] LEN_MAX = LEN_W'(N_EDITS);

  state_t          state;
  logic [IDXW-1:0] idx;
  logic [IDXW:0]   len;
  entry_t          cur;
  entry_t          rd_entry;
  entry_t          wdata;
  logic [IDXW-1:0] rd_idx;
  logic            cfg_ok;
  logic            last;

  assign cfg_ok = (state == ST_IDLE);
  assign wdata  = '{addr: cfg_addr, val: cfg_val, mode: cfg_mode, flag: cfg_flag};

  // The read port looks one entry ahead so the entry for the next EDIT cycle
  // is captured into cur at the same edge idx advances.
  assign rd_idx = (state == ST_EDIT) ? idx + 1'b1 : '0;
  assign last   = ({1'b0, idx} == len - 1'b1);

  edit_table #(
    .N_EDITS(N_EDITS),
    .IDXW   (IDXW)
  ) u_table (
    .clk    (clk),
    .reset_n(reset_n),
    .we     (cfg_we && cfg_ok),
    .widx   (cfg_idx),
    .wdata  (wdata),
    .ridx   (rd_idx),
    .rdata  (rd_entry)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len <= '0;
    end else if (cfg_len_we && cfg_ok) begin
      len <= (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
    end
  end

  // The table cannot change outside IDLE, so the registered copy in cur is
  // the same entry idx points at; the condition is evaluated on live flags.
  assign addr     = cur.addr;
  assign val      = cur.val;
  assign do_write = (state == ST_EDIT) && eval_cond(cur, cond_flags);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      idx           <= '0;
      cur           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      en_edit       <= 1'b0;
      en_load_input <= 1'b0;
      mux_data      <= 1'b0;
    end else if (abort) begin
      state         <= ST_IDLE;
      idx           <= '0;
      cur           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      en_edit       <= 1'b0;
      en_load_input <= 1'b0;
      mux_data      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state         <= ST_LOAD;
            busy          <= 1'b1;
            en_load_input <= 1'b1;
          end
        end
        ST_LOAD: begin
          en_load_input <= 1'b0;
          idx           <= '0;
          if (len == '0) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state    <= ST_EDIT;
            cur      <= rd_entry;
            en_edit  <= 1'b1;
            mux_data <= 1'b1;
          end
        end
        ST_EDIT: begin
          if (last) begin
            state    <= ST_DONE;
            cur      <= '0;
            en_edit  <= 1'b0;
            mux_data <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
            cur <= rd_entry;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_edit_sequencer.sv
// tb/tb_edit_sequencer.sv - self-checking bench for edit_sequencer
//
// Purpose: drives configuration and sequences, compares every cycle of every
//          sequence against a table-level reference model.
// Ports:   none (top-level bench).
module tb_edit_sequencer;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cfg_we, cfg_val, cfg_len_we, start, abort;
  logic [2:0]  cfg_idx;
  logic [4:0]  cfg_addr;
  logic [1:0]  cfg_mode, cfg_flag;
  logic [3:0]  cfg_len, cond_flags;
  logic        busy, done, do_write, val, en_edit, en_load_input, mux_data;
  logic [4:0]  addr;

  edit_sequencer #(.N_EDITS(N)) dut (
    .clk(clk), .reset_n(reset_n),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_val(cfg_val),
    .cfg_mode(cfg_mode), .cfg_flag(cfg_flag),
    .cfg_len_we(cfg_len_we), .cfg_len(cfg_len), .cond_flags(cond_flags),
    .start(start), .abort(abort),
    .busy(busy), .done(done), .addr(addr), .do_write(do_write), .val(val),
    .en_edit(en_edit), .en_load_input(en_load_input), .mux_data(mux_data)
  );

  always #5 clk = ~clk;

  // Output buffer driven by the DUT controls.
  logic [31:0] cur_word, tb_buf;
  always @(posedge clk) begin
    if (en_load_input) tb_buf <= cur_word;
    else if (en_edit && do_write) tb_buf[addr] <= val;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model of the programmed table.
  logic [4:0] m_addr [N];
  logic       m_val  [N];
  logic [1:0] m_mode [N];
  logic [1:0] m_flag [N];
  int         m_len;

  function automatic void model_clear();
    for (int i = 0; i < N; i++) begin
      m_addr[i] = '0; m_val[i] = 1'b0; m_mode[i] = 2'd0; m_flag[i] = 2'd0;
    end
    m_len = 0;
  endfunction

  function automatic logic cond_model(input int k, input logic [3:0] fl);
    case (m_mode[k])
      2'd0:    return 1'b0;
      2'd1:    return 1'b1;
      2'd2:    return fl[m_flag[k]];
      default: return !fl[m_flag[k]];
    endcase
  endfunction

  // Expected {busy,done,load,edit,mux,do_write,val,addr[4:0]} for cycle c of
  // a sequence whose start is high in cycle 0; ab is the abort cycle or -1.
  function automatic logic [11:0] exp_vec(input int c, input int ab, input logic [3:0] fl);
    logic [11:0] v;
    v = '0;
    if (ab >= 0 && c > ab) return v;
    if (c == 1) begin
      v[11] = 1'b1; v[9] = 1'b1;
    end else if (c >= 2 && c <= 1 + m_len) begin
      v[11] = 1'b1; v[8] = 1'b1; v[7] = 1'b1;
      v[6] = cond_model(c - 2, fl);
      v[5] = m_val[c - 2];
      v[4:0] = m_addr[c - 2];
    end else if (c == 2 + m_len) begin
      v[10] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [11:0] sample();
    return {busy, done, en_load_input, en_edit, mux_data, do_write, val, addr};
  endfunction

  task automatic drive_cycle(input logic st, input logic ab, input logic [3:0] fl,
                             output logic [11:0] obs);
    @(negedge clk);
    cfg_we = 1'b0; cfg_len_we = 1'b0;
    start = st; abort = ab; cond_flags = fl;
    #1;
    obs = sample();
  endtask

  task automatic cfg_entry(input int i, input logic [4:0] a, input logic v,
                           input logic [1:0] md, input logic [1:0] fg);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = 3'(i); cfg_addr = a; cfg_val = v; cfg_mode = md; cfg_flag = fg;
    m_addr[i] = a; m_val[i] = v; m_mode[i] = md; m_flag[i] = fg;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic cfg_length(input int l);
    @(negedge clk);
    cfg_len_we = 1'b1; cfg_len = 4'(l);
    m_len = (l > N) ? N : l;
    @(negedge clk);
    cfg_len_we = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] obs, ev;
    reset_n = 1'b0;
    cfg_we = 0; cfg_len_we = 0; start = 0; abort = 0; cond_flags = 0;
    cfg_idx = 0; cfg_addr = 0; cfg_val = 0; cfg_mode = 0; cfg_flag = 0; cfg_len = 0;
    cur_word = 32'hA5A5_0F0F;
    model_clear();
    #1;
    n_tests++;
    if (sample() !== 12'h000) begin
      n_fail++; $display("FAIL reset_outputs: got %h want 000", sample());
    end
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c <= 3; c++) begin
      drive_cycle(c == 0, 1'b0, 4'h0, obs);
      ev = exp_vec(c, -1, 4'h0);
      n_tests++;
      if (obs !== ev) begin
        n_fail++; $display("FAIL reset_empty_run c%0d: got %h want %h", c, obs, ev);
      end
    end
  endtask

  task automatic test_basic();
    logic [11:0] obs, ev;
    cfg_entry(0, 5'd5, 1'b1, 2'd1, 2'd0);
    cfg_entry(1, 5'd0, 1'b0, 2'd1, 2'd0);
    cfg_entry(2, 5'd31, 1'b1, 2'd0, 2'd0);
    cfg_length(3);
    cur_word = 32'h0000_0001;
    for (int c = 0; c <= 6; c++) begin
      drive_cycle(c == 0, 1'b0, 4'($urandom), obs);
      ev = exp_vec(c, -1, cond_flags);
      n_tests++;
      if (obs !== ev) begin
        n_fail++; $display("FAIL basic c%0d: got %h want %h", c, obs, ev);
      end
      if (c == 5) begin
        n_tests++;
        if (tb_buf !== 32'h0000_0020) begin
          n_fail++; $display("FAIL basic_result: got %h want 00000020", tb_buf);
        end
      end
    end
  endtask

  task automatic test_cond();
    logic [11:0] obs, ev;
    logic exp_mid;
    for (int m = 2; m <= 3; m++) begin
      cfg_entry(0, 5'd7, 1'b1, 2'(m), 2'd2);
      cfg_length(1);
      for (int c = 0; c <= 3; c++) begin
        drive_cycle(c == 0, 1'b0, 4'h0, obs);
        ev = exp_vec(c, -1, 4'h0);
        n_tests++;
        if (obs !== ev) begin
          n_fail++; $display("FAIL cond m%0d c%0d: got %h want %h", m, c, obs, ev);
        end
        if (c == 2) begin
          cond_flags = 4'b0100;
          #1;
          exp_mid = cond_model(0, 4'b0100);
          n_tests++;
          if (do_write !== exp_mid) begin
            n_fail++; $display("FAIL cond_live m%0d: got %b want %b", m, do_write, exp_mid);
          end
        end
      end
    end
  endtask

  task automatic test_abort();
    logic [11:0] obs, ev;
    for (int i = 0; i < 4; i++)
      cfg_entry(i, 5'($urandom), 1'($urandom), 2'($urandom), 2'($urandom));
    cfg_length(4);
    // Abort during the second edit (cycle 3).
    for (int c = 0; c <= 3; c++) begin
      drive_cycle(c == 0, c == 3, 4'($urandom), obs);
      ev = exp_vec(c, 3, cond_flags);
      n_tests++;
      if (obs !== ev) begin
        n_fail++; $display("FAIL abort c%0d: got %h want %h", c, obs, ev);
      end
    end
    // Next cycle must be IDLE with nothing asserted, and a start there is taken.
    for (int c = 0; c <= 7; c++) begin
      drive_cycle(c == 0, 1'b0, 4'($urandom), obs);
      ev = exp_vec(c, -1, cond_flags);
      n_tests++;
      if (obs !== ev) begin
        n_fail++; $display("FAIL abort_restart c%0d: got %h want %h", c, obs, ev);
      end
    end
  endtask

  task automatic test_len_clamp();
    logic [11:0] obs, ev;
    int n_edit;
    for (int i = 0; i < N; i++) cfg_entry(i, 5'(i * 3 + 1), 1'(i), 2'd1, 2'd0);
    cfg_length(15);
    for (int pass = 0; pass < 2; pass++) begin
      n_edit = 0;
      for (int c = 0; c <= N + 3; c++) begin
        drive_cycle(c == 0, 1'b0, 4'($urandom), obs);
        ev = exp_vec(c, -1, cond_flags);
        if (obs[8]) n_edit++;
        n_tests++;
        if (obs !== ev) begin
          n_fail++; $display("FAIL len_clamp p%0d c%0d: got %h want %h", pass, c, obs, ev);
        end
        if (pass == 0 && c == 3) begin
          cfg_we = 1'b1; cfg_idx = 3'd0; cfg_addr = 5'd30; cfg_val = 1'b0;
          cfg_mode = 2'd0; cfg_flag = 2'd3;
        end
      end
      n_tests++;
      if (n_edit != N) begin
        n_fail++; $display("FAIL len_clamp_count p%0d: got %0d want %0d", pass, n_edit, N);
      end
    end
  endtask

  task automatic test_random();
    logic [11:0] obs, ev;
    logic [31:0] exp_buf;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++)
        cfg_entry(i, 5'($urandom), 1'($urandom), 2'($urandom), 2'($urandom));
      cfg_length($urandom_range(0, 15));
      cur_word = $urandom;
      exp_buf = '0;
      for (int c = 0; c <= m_len + 3; c++) begin
        drive_cycle(c == 0, 1'b0, 4'($urandom), obs);
        ev = exp_vec(c, -1, cond_flags);
        n_tests++;
        if (obs !== ev) begin
          n_fail++; $display("FAIL random r%0d c%0d: got %h want %h", r, c, obs, ev);
        end
        if (c == 1) exp_buf = cur_word;
        if (c >= 2 && c <= 1 + m_len && cond_model(c - 2, cond_flags))
          exp_buf[m_addr[c - 2]] = m_val[c - 2];
        if (c == 2 + m_len) begin
          n_tests++;
          if (tb_buf !== exp_buf) begin
            n_fail++; $display("FAIL random_result r%0d: got %h want %h", r, tb_buf, exp_buf);
          end
        end
      end
    end
  endtask

  task automatic test_async_reset();
    logic [11:0] obs, ev;
    for (int i = 0; i < 3; i++) cfg_entry(i, 5'(i + 9), 1'b1, 2'd1, 2'd0);
    cfg_length(3);
    for (int c = 0; c <= 3; c++) begin
      drive_cycle(c == 0, 1'b0, 4'h0, obs);
      ev = exp_vec(c, -1, 4'h0);
      n_tests++;
      if (obs !== ev) begin
        n_fail++; $display("FAIL async_pre c%0d: got %h want %h", c, obs, ev);
      end
    end
    #1 reset_n = 1'b0;
    #1;
    model_clear();
    n_tests++;
    if (sample() !== 12'h000) begin
      n_fail++; $display("FAIL async_clear: got %h want 000", sample());
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) cfg_length(1);
      for (int c = 0; c <= m_len + 3; c++) begin
        drive_cycle(c == 0, 1'b0, 4'($urandom), obs);
        ev = exp_vec(c, -1, cond_flags);
        n_tests++;
        if (obs !== ev) begin
          n_fail++; $display("FAIL async_post p%0d c%0d: got %h want %h", pass, c, obs, ev);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cond();
    test_abort();
    test_len_clamp();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
